// File: rtl/router_fifo_if.sv
// Write/read handshake and status bundle between the router synchronizer,
// the destination port and one router_fifo.
interface router_fifo_if;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic       full;
  logic       empty;
  logic [7:0] data_out;
  logic       pkt_active;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  full, empty, data_out, pkt_active
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output full, empty, data_out, pkt_active
  );
endinterface

// File: rtl/router_fifo.sv
// 16-entry packet FIFO for one router output port. Each entry carries a header
// flag so the read side can track how many bytes of the current packet remain.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          soft_reset,
  router_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  dout_q, dout_d;
  logic        pkt_q, pkt_d;

  logic             full_c;
  logic             empty_c;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] rd_entry;

  // Extra wrap bit distinguishes full from empty when the addresses match.
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

  assign wr_acc   = bus.write_enb && !full_c && !soft_reset;
  assign rd_acc   = bus.read_enb && !empty_c && !soft_reset;
  assign rd_entry = mem[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (soft_reset) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      dout_d = 8'h00;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_ONE;
      if (rd_acc) begin
        rptr_d = rptr_q + PTR_ONE;
        dout_d = rd_entry[7:0];
        // A header always reloads, even if the previous packet was cut short.
        if (rd_entry[8])           cnt_d = {1'b0, rd_entry[7:2]} + 7'd1;
        else if (cnt_q != 7'd0)    cnt_d = cnt_q - 7'd1;
      end else if (cnt_q == 7'd0) begin
        dout_d = 8'h00;
      end
    end
    pkt_d = (cnt_d != 7'd0);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= 8'h00;
      pkt_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      pkt_q  <= pkt_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  assign bus.full       = full_c;
  assign bus.empty      = empty_c;
  assign bus.data_out   = dout_q;
  assign bus.pkt_active = pkt_q;

endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: packet flow, full/empty corners, pointer
// wrap, truncated headers, soft and hard reset.
module tb_router_fifo;

  logic clock;
  logic resetn;
  logic soft_reset;
  int   total;
  int   bad;

  router_fifo_if bus ();

  router_fifo #(.DEPTH(16), .WIDTH(9)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic lfd, input logic [7:0] d);
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn     = 1'b0;
    soft_reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_pkt", bus.pkt_active, 0);
    chk("rst_dout", bus.data_out, 8'h00);
    step();
    step();
    resetn = 1'b1;
    step();

    // Header 0E (length 3), three payload bytes and parity
    drive(1'b1, 1'b0, 1'b1, 8'h0E);
    step();
    chk("wr1_empty", bus.empty, 0);
    drive(1'b1, 1'b0, 1'b0, 8'hA1); step();
    drive(1'b1, 1'b0, 1'b0, 8'hA2); step();
    drive(1'b1, 1'b0, 1'b0, 8'hA3); step();
    drive(1'b1, 1'b0, 1'b0, 8'h5C); step();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("pk_hdr", bus.data_out, 8'h0E);
    chk("pk_act0", bus.pkt_active, 1);
    step();
    chk("pk_p0", bus.data_out, 8'hA1);
    chk("pk_act1", bus.pkt_active, 1);
    step();
    chk("pk_p1", bus.data_out, 8'hA2);
    step();
    chk("pk_p2", bus.data_out, 8'hA3);
    chk("pk_act3", bus.pkt_active, 1);
    chk("pk_nempty4", bus.empty, 0);
    step();
    chk("pk_par", bus.data_out, 8'h5C);
    chk("pk_act4", bus.pkt_active, 0);
    chk("pk_empty5", bus.empty, 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk("pk_idle_dout", bus.data_out, 8'h00);

    // Fill to 16, drop 17th, drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h10 + 8'(i));
      step();
      chk("fill_full", bus.full, (i == 15) ? 1 : 0);
    end
    drive(1'b1, 1'b0, 1'b0, 8'hFF);
    step();
    chk("drop_full", bus.full, 1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("drain_data", bus.data_out, 8'h10 + 8'(i));
      chk("drain_full", bus.full, 0);
    end
    chk("drain_empty", bus.empty, 1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk("drain_idle", bus.data_out, 8'h00);

    // Read+write while full: only the read goes through
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i));
      step();
    end
    chk("rw_full_pre", bus.full, 1);
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    step();
    chk("rw_full_dout", bus.data_out, 8'h20);
    chk("rw_full_flag", bus.full, 0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("rw_full_drain", bus.data_out, 8'h20 + 8'(i));
      chk("rw_full_emp", bus.empty, (i == 15) ? 1 : 0);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    step();

    // Read+write while empty: only the write goes through
    drive(1'b1, 1'b1, 1'b0, 8'h99);
    step();
    chk("rw_emp_dout", bus.data_out, 8'h00);
    chk("rw_emp_flag", bus.empty, 0);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("rw_emp_rd", bus.data_out, 8'h99);
    chk("rw_emp_occ1", bus.empty, 1);

    // Interleaved 20 writes / 20 reads across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i >= 2), 1'b0, 8'h40 + 8'(i));
      step();
      if (i >= 2) chk("wrap_data", bus.data_out, 8'h40 + 8'(i - 2));
      chk("wrap_empty", bus.empty, 0);
      chk("wrap_full", bus.full, 0);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("wrap_t0", bus.data_out, 8'h52);
    step();
    chk("wrap_t1", bus.data_out, 8'h53);
    chk("wrap_end_empty", bus.empty, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
      step();
    end
    chk("wrap_refull", bus.full, 1);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("wrap_redrain", bus.data_out, 8'h60 + 8'(i));
    end
    chk("wrap_reempty", bus.empty, 1);

    // Truncated packet reload and zero-length header
    drive(1'b1, 1'b0, 1'b1, 8'h04); step();
    drive(1'b1, 1'b0, 1'b1, 8'h00); step();
    drive(1'b1, 1'b0, 1'b0, 8'h33); step();
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("trunc_h1", bus.pkt_active, 1);
    step();
    chk("trunc_h0", bus.data_out, 8'h00);
    chk("trunc_act", bus.pkt_active, 1);
    step();
    chk("trunc_byte", bus.data_out, 8'h33);
    chk("trunc_done", bus.pkt_active, 0);

    // Soft reset with 7 entries held mid-packet; same-cycle requests discarded
    drive(1'b1, 1'b0, 1'b1, 8'h18); step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'hB0 + 8'(i));
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    step();
    chk("sr_hdr", bus.data_out, 8'h18);
    chk("sr_act_pre", bus.pkt_active, 1);
    drive(1'b1, 1'b1, 1'b0, 8'hEE);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    chk("sr_empty", bus.empty, 1);
    chk("sr_pkt", bus.pkt_active, 0);
    chk("sr_dout", bus.data_out, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h55); step();
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    chk("sr_after", bus.data_out, 8'h55);
    chk("sr_after_emp", bus.empty, 1);

    // Hard reset mid-packet acts without a clock edge
    drive(1'b1, 1'b0, 1'b1, 8'h08); step();
    drive(1'b1, 1'b0, 1'b0, 8'hC1); step();
    drive(1'b1, 1'b0, 1'b0, 8'hC2); step();
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    chk("hr_hdr", bus.data_out, 8'h08);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    resetn = 1'b0;
    #1;
    chk("hr_empty", bus.empty, 1);
    chk("hr_full", bus.full, 0);
    chk("hr_pkt", bus.pkt_active, 0);
    chk("hr_dout", bus.data_out, 8'h00);
    step();
    resetn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'hAB); step();
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    chk("hr_after", bus.data_out, 8'hAB);
    chk("hr_after_emp", bus.empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port soft_reset, input, 1 bit: synchronous flush from the synchronizer; active high.
REQ-004 The block SHALL have port write_enb, input, 1 bit: one bit of the synchronizer's one-hot write_enb; requests a write of data_in.
REQ-005 The block SHALL have port read_enb, input, 1 bit: read request from the destination port.
REQ-006 The block SHALL have port lfd_state, input, 1 bit: marks the current data_in as a packet header byte.
REQ-007 The block SHALL have port data_in, input, 8 bits: header byte (addr in [1:0], payload length in [7:2]), payload byte or parity byte.
REQ-008 The block SHALL have port full, output, 1 bit: 16 entries held.
REQ-009 The block SHALL have port empty, output, 1 bit: 0 entries held.
REQ-010 The block SHALL have port data_out, output, 8 bits: registered read data.
REQ-011 The block SHALL have port pkt_active, output, 1 bit: high while the packet byte counter is nonzero.
REQ-012 The block SHALL have parameters DEPTH = 16 (entries) and WIDTH = 9 (bit 8 = header flag, bits 7:0 = data).

Function
REQ-013 Storage SHALL be 16 x 9 bits, addressed by 5-bit write and read pointers: 4 address bits plus 1 wrap bit.
REQ-014 empty SHALL be 1 when the pointers are equal in all 5 bits; full SHALL be 1 when address bits are equal and wrap bits differ; both outputs SHALL be combinational from the pointers.
REQ-015 A write SHALL be accepted when write_enb=1 and full=0: entry[wptr] <= {lfd_state, data_in}, and wptr increments by 1 modulo 32.
REQ-016 A read SHALL be accepted when read_enb=1 and empty=0: data_out <= entry[rptr][7:0] on the same edge (1-cycle latency), and rptr increments by 1 modulo 32.
REQ-017 A write with full=1 SHALL be dropped with no change to state; a read with empty=1 SHALL be ignored, and data_out SHALL hold its value.
REQ-018 Simultaneous read and write with 0 < occupancy < 16 SHALL both be accepted, leaving occupancy unchanged.
REQ-019 Simultaneous read and write with full=1 SHALL accept only the read; with empty=1 they SHALL accept only the write. The outcome is defined by the flag values before the edge.
REQ-020 The packet counter is 7 bits. On an accepted read of an entry with bit 8 = 1, the counter SHALL load data[7:2] + 1 (payload plus parity).
REQ-021 On an accepted read of an entry with bit 8 = 0 while the counter is nonzero, the counter SHALL decrement by 1; it SHALL never decrement below 0.
REQ-022 A header read while the counter is nonzero (truncated packet) SHALL reload the counter from the new header; no error is flagged.
REQ-023 A header with payload length 0 SHALL load the counter with 1.
REQ-024 pkt_active SHALL equal (counter != 0), registered with the counter.
REQ-025 When the counter is 0 and no read is accepted, data_out SHALL be driven to 8'h00 on the next edge.
REQ-026 Operation SHALL observe this priority order: resetn, then soft_reset, then read/write.

Reset
REQ-027 When resetn=0, asynchronously: wptr=0, rptr=0, counter=0, data_out=8'h00, empty=1, full=0, pkt_active=0. Memory contents need not be cleared.
REQ-028 When soft_reset=1 at an edge: pointers, counter and data_out SHALL clear to the reset values; any write or read requested in the same cycle SHALL be discarded.
REQ-029 Asserting resetn mid-packet SHALL abandon that packet. The first write after release SHALL land at entry 0.

Verification
REQ-030 Reset, then write header 8'h0E with lfd_state=1 (length 3), then 3 payload bytes and 1 parity byte -> empty=0 after the first write, and occupancy = 5.
REQ-031 Read the packet from REQ-030 continuously -> data_out = 0E, p0, p1, p2, parity on consecutive cycles, each 1 cycle after its read; pkt_active is high from the header read until the parity read; data_out = 00 on the cycle after that; empty=1 after the 5th read.
REQ-032 Write 16 entries -> full=1. A 17th write is dropped: reading all 16 entries returns the original 16 in order.
REQ-033 With full=1, assert read_enb and write_enb together -> occupancy = 15 and full=0. With empty=1, assert both together -> occupancy = 1 and data_out is unchanged.
REQ-034 Write 20 entries and read 20 entries interleaved, so the pointers wrap -> data returns in order, and the full and empty flags are correct at the wrap.
REQ-035 Pulse soft_reset with 7 entries held and pkt_active=1 -> empty=1, pkt_active=0, data_out=00 on the next cycle. Pulse resetn low mid-packet -> the same values immediately, without waiting for a clock edge.
